// File: rtl/poly_arith_pkg.sv
// Shared ML-KEM polynomial arithmetic types: modulus, coefficient/index types,
// sequencer states and the read-pipeline payload.
package poly_arith_pkg;

  localparam int unsigned COEFF_W = 12;
  localparam int unsigned Q       = 3329;
  localparam int unsigned POLY_N  = 256;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned RAM_LAT = 1;
  localparam int unsigned ADD_LAT = 2;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [IDX_W-1:0]   poly_idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic      valid;
    poly_idx_t addr;
  } rd_tag_t;

endpackage

// File: rtl/mod_add.sv
// Two-stage modular adder: (a + b) mod Q for operands already reduced below Q.
module mod_add
  import poly_arith_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_i,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output logic   valid_o,
  output coeff_t result_o,
  output logic   pend_o
);

  localparam int unsigned SUM_W = COEFF_W + 1;

  logic             r_v1;
  logic [SUM_W-1:0] r_sum;
  logic             r_v2;
  coeff_t           r_res;

  // Stage 1 forms the raw sum, stage 2 applies the single conditional subtract.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_sum <= '0;
      r_v2  <= 1'b0;
      r_res <= '0;
    end else begin
      r_v1  <= valid_i;
      r_sum <= SUM_W'(a_i) + SUM_W'(b_i);
      r_v2  <= r_v1;
      r_res <= (r_sum >= SUM_W'(Q)) ? COEFF_W'(r_sum - SUM_W'(Q)) : COEFF_W'(r_sum);
    end
  end

  assign valid_o  = r_v2;
  assign result_o = r_res;
  assign pend_o   = r_v1;

endmodule

// File: rtl/poly_add_seq.sv
// Streams a whole polynomial pair from the coefficient RAMs through mod_add and
// writes the results back. Define POLY_ADD_SUB_EN to add op_sub_i (a - b mod Q).
module poly_add_seq
  import poly_arith_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start_i,
`ifdef POLY_ADD_SUB_EN
  input  logic      op_sub_i,
`endif
  input  logic      stall_i,
  output logic      busy_o,
  output logic      done_o,
  output logic      rd_en_o,
  output poly_idx_t rd_addr_o,
  input  coeff_t    a_rdata_i,
  input  coeff_t    b_rdata_i,
  output logic      wr_en_o,
  output poly_idx_t wr_addr_o,
  output coeff_t    wr_data_o
);

  seq_state_t r_state, w_state_nxt;
  poly_idx_t  r_index, w_index_nxt;
  logic       r_op_sub, w_op_sub_nxt, w_op_sub_start;
  logic       w_issue;
  logic       w_rd_pend;
  logic       w_add_pend;
  logic       w_add_valid;
  coeff_t     w_add_result;
  coeff_t     w_b_eff;
  rd_tag_t    r_rd_pipe [RAM_LAT];
  poly_idx_t  r_wr_addr [ADD_LAT];

`ifdef POLY_ADD_SUB_EN
  assign w_op_sub_start = op_sub_i;
`else
  assign w_op_sub_start = 1'b0;
`endif

  always_comb begin
    w_rd_pend = 1'b0;
    for (int unsigned k = 0; k < RAM_LAT; k++) begin
      w_rd_pend = w_rd_pend | r_rd_pipe[k].valid;
    end
  end

  // Next-state logic; DRAIN exits once only the write stage can still be valid,
  // so done_o lands one cycle after the final write.
  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_op_sub_nxt = r_op_sub;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt  = S_RUN;
          w_index_nxt  = '0;
          w_op_sub_nxt = w_op_sub_start;
        end
      end
      S_RUN: begin
        if (!stall_i) begin
          w_issue     = 1'b1;
          w_index_nxt = r_index + IDX_W'(1);
          if (r_index == IDX_W'(POLY_N - 1)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!w_rd_pend && !w_add_pend) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_index  <= '0;
      r_op_sub <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_op_sub <= w_op_sub_nxt;
    end
  end

  // Read tag line tracks RAM latency; address line tracks mod_add latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < RAM_LAT; k++) r_rd_pipe[k] <= '0;
      for (int unsigned k = 0; k < ADD_LAT; k++) r_wr_addr[k] <= '0;
    end else begin
      r_rd_pipe[0] <= '{valid: w_issue, addr: r_index};
      for (int unsigned k = 1; k < RAM_LAT; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
      r_wr_addr[0] <= r_rd_pipe[RAM_LAT-1].addr;
      for (int unsigned k = 1; k < ADD_LAT; k++) r_wr_addr[k] <= r_wr_addr[k-1];
    end
  end

  assign w_b_eff = (r_op_sub && (b_rdata_i != '0)) ? COEFF_W'(COEFF_W'(Q) - b_rdata_i)
                                                   : b_rdata_i;

  mod_add u_mod_add (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (r_rd_pipe[RAM_LAT-1].valid),
    .a_i      (a_rdata_i),
    .b_i      (w_b_eff),
    .valid_o  (w_add_valid),
    .result_o (w_add_result),
    .pend_o   (w_add_pend)
  );

  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign rd_en_o   = w_issue;
  assign rd_addr_o = r_index;
  assign wr_en_o   = w_add_valid;
  assign wr_addr_o = r_wr_addr[ADD_LAT-1];
  assign wr_data_o = w_add_result;

endmodule

// File: tb/tb_poly_add_seq.sv
// Directed bench for poly_add_seq with a latency-1 RAM model; covers reset,
// add, wrap, stall, ignored start and (when POLY_ADD_SUB_EN) subtraction.
module tb_poly_add_seq;
  import poly_arith_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      start_i;
  logic      op_sub;
  logic      stall_i;
  logic      busy_o, done_o, rd_en_o, wr_en_o;
  poly_idx_t rd_addr_o, wr_addr_o;
  coeff_t    a_rdata, b_rdata, wr_data_o;

  coeff_t a_mem [256];
  coeff_t b_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  poly_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
`ifdef POLY_ADD_SUB_EN
    .op_sub_i  (op_sub),
`endif
    .stall_i   (stall_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .a_rdata_i (a_rdata),
    .b_rdata_i (b_rdata),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o)
  );

  always @(posedge clk) begin
    if (rd_en_o) begin
      a_rdata <= a_mem[rd_addr_o];
      b_rdata <= b_mem[rd_addr_o];
    end
  end

  function automatic int exp_val(input bit sub, input int a, input int b);
    if (sub) return (a + 3329 - b) % 3329;
    return (a + b) % 3329;
  endfunction

  // Runs one full operation (start at cycle 0) and gathers observations.
  task automatic do_run(input bit sub, input bit stall_en, input bit extra_starts,
                        output int n_wr, output int n_bad_ord, output int n_bad_dat,
                        output int n_done, output int done_cyc, output int n_rd,
                        output int n_rd_stalled, output int n_late, output int last_dat);
    int  exp_wr, exp_rd, left;
    bit  f100, f255;
    n_wr = 0; n_bad_ord = 0; n_bad_dat = 0; n_done = 0; done_cyc = -1;
    n_rd = 0; n_rd_stalled = 0; n_late = 0; last_dat = -1;
    exp_wr = 0; exp_rd = 0; left = 0; f100 = 0; f255 = 0;
    @(posedge clk); #1;
    start_i = 1'b1; op_sub = sub; stall_i = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start_i = extra_starts && (cyc == 10 || cyc == 200);
      if (stall_en && busy_o && !done_o) begin
        if (rd_addr_o == 8'd100 && !f100) begin left = 5; f100 = 1; end
        if (rd_addr_o == 8'd255 && !f255) begin left = 1; f255 = 1; end
      end
      stall_i = (left > 0);
      if (left > 0) left--;
      @(negedge clk);
      if (rd_en_o) begin
        if (stall_i) n_rd_stalled++;
        if (int'(rd_addr_o) != exp_rd) n_bad_ord++;
        exp_rd++;
        n_rd++;
      end
      if (wr_en_o) begin
        if (int'(wr_addr_o) != exp_wr) n_bad_ord++;
        if (exp_wr < 256 &&
            int'(wr_data_o) != exp_val(sub, int'(a_mem[exp_wr]), int'(b_mem[exp_wr])))
          n_bad_dat++;
        last_dat = int'(wr_data_o);
        exp_wr++;
        n_wr++;
      end
      if (done_o) begin
        if (n_done == 0) done_cyc = cyc;
        n_done++;
      end
      if (done_cyc >= 0 && cyc > done_cyc && (busy_o || rd_en_o || wr_en_o)) n_late++;
      if (done_cyc >= 0 && cyc > done_cyc + 10) break;
    end
    start_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: begin a_mem[i] = COEFF_W'(i);    b_mem[i] = COEFF_W'(3328 - i); end
        1: begin a_mem[i] = COEFF_W'(3328); b_mem[i] = COEFF_W'(3328);     end
        2: begin a_mem[i] = COEFF_W'(3328); b_mem[i] = COEFF_W'(1);        end
        3: begin a_mem[i] = COEFF_W'(5);    b_mem[i] = COEFF_W'(10);       end
        default: begin a_mem[i] = COEFF_W'(5); b_mem[i] = COEFF_W'(0);     end
      endcase
    end
  endtask

  task automatic test_reset();
    int n_wr, bo, bd, nd, dc, nr, nrs, nl, ld, wr_after;
    fill(0);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, rd_en_o, wr_en_o} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got busy/done/rd/wr=%b required 0000",
               {busy_o, done_o, rd_en_o, wr_en_o});
    end
    n_checks++;
    if (rd_addr_o !== '0 || wr_addr_o !== '0 || wr_data_o !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got rd_addr=%0d wr_addr=%0d wr_data=%0d required 0 0 0",
               rd_addr_o, wr_addr_o, wr_data_o);
    end
    rst = 1'b0;
    wr_after = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en_o || busy_o) wr_after++;
    end
    n_checks++;
    if (wr_after !== 0) begin
      n_errors++;
      $display("FAIL reset_no_write: got %0d active cycles after reset required 0", wr_after);
    end
    do_run(0, 0, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || bo !== 0 || bd !== 0 || nd !== 1) begin
      n_errors++;
      $display("FAIL reset_restart: got writes=%0d bad_ord=%0d bad_dat=%0d done=%0d required 256 0 0 1",
               n_wr, bo, bd, nd);
    end
  endtask

  task automatic test_full_add();
    int n_wr, bo, bd, nd, dc, nr, nrs, nl, ld;
    fill(0);
    do_run(0, 0, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || nr !== 256) begin
      n_errors++;
      $display("FAIL add_count: got writes=%0d reads=%0d required 256 256", n_wr, nr);
    end
    n_checks++;
    if (bo !== 0) begin
      n_errors++;
      $display("FAIL add_order: got %0d out-of-order required 0", bo);
    end
    n_checks++;
    if (bd !== 0 || ld !== 3328) begin
      n_errors++;
      $display("FAIL add_data: got bad=%0d last=%0d required 0 3328", bd, ld);
    end
    n_checks++;
    if (nd !== 1 || dc !== 260) begin
      n_errors++;
      $display("FAIL add_done: got count=%0d cycle=%0d required 1 260", nd, dc);
    end
  endtask

  task automatic test_wrap();
    int n_wr, bo, bd, nd, dc, nr, nrs, nl, ld;
    fill(1);
    do_run(0, 0, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || bd !== 0 || ld !== 3327) begin
      n_errors++;
      $display("FAIL wrap_3327: got writes=%0d bad=%0d last=%0d required 256 0 3327", n_wr, bd, ld);
    end
    fill(2);
    do_run(0, 0, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || bd !== 0 || ld !== 0) begin
      n_errors++;
      $display("FAIL wrap_zero: got writes=%0d bad=%0d last=%0d required 256 0 0", n_wr, bd, ld);
    end
  endtask

  task automatic test_stall();
    int n_wr, bo, bd, nd, dc, nr, nrs, nl, ld;
    fill(0);
    do_run(0, 1, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || bo !== 0 || bd !== 0) begin
      n_errors++;
      $display("FAIL stall_writes: got writes=%0d bad_ord=%0d bad_dat=%0d required 256 0 0",
               n_wr, bo, bd);
    end
    n_checks++;
    if (nrs !== 0) begin
      n_errors++;
      $display("FAIL stall_rd_en: got %0d reads while stalled required 0", nrs);
    end
    n_checks++;
    if (nd !== 1 || dc !== 266) begin
      n_errors++;
      $display("FAIL stall_done: got count=%0d cycle=%0d required 1 266", nd, dc);
    end
  endtask

  task automatic test_ignored_start();
    int n_wr, bo, bd, nd, dc, nr, nrs, nl, ld;
    fill(0);
    do_run(0, 0, 1, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (nd !== 1 || dc !== 260) begin
      n_errors++;
      $display("FAIL ign_done: got count=%0d cycle=%0d required 1 260", nd, dc);
    end
    n_checks++;
    if (n_wr !== 256 || bo !== 0 || nl !== 0) begin
      n_errors++;
      $display("FAIL ign_writes: got writes=%0d bad_ord=%0d late=%0d required 256 0 0",
               n_wr, bo, nl);
    end
  endtask

`ifdef POLY_ADD_SUB_EN
  task automatic test_sub();
    int n_wr, bo, bd, nd, dc, nr, nrs, nl, ld;
    fill(3);
    do_run(1, 0, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || bd !== 0 || ld !== 3324) begin
      n_errors++;
      $display("FAIL sub_neg: got writes=%0d bad=%0d last=%0d required 256 0 3324", n_wr, bd, ld);
    end
    fill(4);
    do_run(1, 0, 0, n_wr, bo, bd, nd, dc, nr, nrs, nl, ld);
    n_checks++;
    if (n_wr !== 256 || bd !== 0 || ld !== 5) begin
      n_errors++;
      $display("FAIL sub_zero: got writes=%0d bad=%0d last=%0d required 256 0 5", n_wr, bd, ld);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start_i = 1'b0; op_sub = 1'b0; stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, rd_en_o, wr_en_o} !== 4'b0000 || wr_data_o !== '0) begin
      n_errors++;
      $display("FAIL init_reset: got busy/done/rd/wr=%b wr_data=%0d required 0000 0",
               {busy_o, done_o, rd_en_o, wr_en_o}, wr_data_o);
    end
    rst = 1'b0;
    test_full_add();
    test_wrap();
    test_stall();
    test_ignored_start();
    test_reset();
`ifdef POLY_ADD_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
